// File: rtl/seq_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional two's-complement operation is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          rdy,
  output logic          busy,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_sr;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_rdy;
  logic          r_busy;
  logic          r_dbz;

  logic          w_accept;
  logic          w_dvs_zero;
  logic          w_last;
  logic [DW-1:0] w_dd_mag;
  logic [VW-1:0] w_dv_mag;
  logic [VW:0]   w_t;
  logic          w_ge;
  logic [VW-1:0] w_rem_nxt;
  logic [DW-1:0] w_sr_nxt;
  logic [DW-1:0] w_q_fin;
  logic [VW-1:0] w_r_fin;

  assign w_accept   = start && (r_state != S_RUN);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(DW - 1));

`ifdef SEQ_DIV_SIGNED_EN
  logic w_dd_neg;
  logic w_dv_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dd_neg = dividend[DW-1];
  assign w_dv_neg = divisor[VW-1];
  // The most-negative dividend maps to 2**(DW-1), which still fits as an unsigned magnitude.
  assign w_dd_mag = w_dd_neg ? (~dividend + DW'(1)) : dividend;
  assign w_dv_mag = w_dv_neg ? (~divisor + VW'(1)) : divisor;
`else
  assign w_dd_mag = dividend;
  assign w_dv_mag = divisor;
`endif

  // One restoring step: the shifted remainder needs VW+1 bits before the compare, but the
  // difference is below the divisor whenever it is taken, so VW bits of it suffice.
  assign w_t       = {r_rem, r_sr[DW-1]};
  assign w_ge      = (w_t >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_t[VW-1:0] - r_dvs) : w_t[VW-1:0];
  assign w_sr_nxt  = {r_sr[DW-2:0], w_ge};

`ifdef SEQ_DIV_SIGNED_EN
  assign w_q_fin = r_neg_q ? (~w_sr_nxt + DW'(1)) : w_sr_nxt;
  assign w_r_fin = r_neg_r ? (~w_rem_nxt + VW'(1)) : w_rem_nxt;
`else
  assign w_q_fin = w_sr_nxt;
  assign w_r_fin = w_rem_nxt;
`endif

  // NOTE: the next-state value is given its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register here is written with <= so all of them sample their inputs at the
  // same edge; a blocking = would let later statements see values updated this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sr  <= w_dd_mag;
        r_dvs <= w_dv_mag;
        r_rem <= '0;
        r_cnt <= '0;
        r_rdy <= 1'b0;
        r_dbz <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
        r_neg_q <= w_dd_neg ^ w_dv_neg;
        r_neg_r <= w_dd_neg;
`endif
        if (w_dvs_zero) begin
          r_q   <= '1;
          r_r   <= dividend[VW-1:0];
          r_dbz <= 1'b1;
          r_rdy <= 1'b1;
        end else begin
          r_busy <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_sr  <= w_sr_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_q    <= w_q_fin;
          r_r    <= w_r_fin;
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign rdy         = r_rdy;
  assign busy        = r_busy;
  assign div_by_zero = r_dbz;

  // Restoring invariant: the partial remainder never reaches the divisor while iterating.
  a_rem_lt_dvs: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_RUN) |-> (r_rem < r_dvs));

  a_rdy_busy_excl: assert property (@(posedge clk) disable iff (reset)
    !(r_rdy && r_busy));

  a_busy_run: assert property (@(posedge clk) disable iff (reset)
    r_busy == (r_state == S_RUN));

endmodule
